// File: rtl/reg32.sv
// reg32: clocked storage register with write echo and nonzero flag.
// Optional same-cycle read bypass: define REG32_READ_BYPASS_EN.
module reg32 #(
  parameter int unsigned WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] writedata,
  input  logic             wen,
  output logic [WIDTH-1:0] readdata,
  output logic             wrote,
  output logic             nonzero
);

  logic [WIDTH-1:0] q;

  // Capture on enabled edges; reset forces q and the echo immediately.
  // The ternary lets an unknown wen poison q in simulation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q     <= RESET_VALUE;
      wrote <= 1'b0;
    end else begin
      q     <= wen ? writedata : q;
      wrote <= wen;
    end
  end

  // Flag reflects the stored value, never the bypassed one.
  always_comb begin
    nonzero = |q;
  end

`ifdef REG32_READ_BYPASS_EN
  // Forward the in-flight write for write-before-read register files.
  always_comb begin
    readdata = q;
    if (wen && reset)
      readdata = writedata;
  end
`else
  // Straight from the flop: one-cycle write latency.
  always_comb begin
    readdata = q;
  end
`endif

endmodule

// File: tb/tb_reg32.sv
// tb_reg32: directed-vector self-checking bench for reg32.
// Expected values are hand-computed constants.
module tb_reg32;

  logic        clk;
  logic        reset;
  logic [31:0] writedata;
  logic        wen;
  logic [31:0] readdata;
  logic        wrote;
  logic        nonzero;

  int total;
  int bad;

  reg32 dut (
    .clk       (clk),
    .reset     (reset),
    .writedata (writedata),
    .wen       (wen),
    .readdata  (readdata),
    .wrote     (wrote),
    .nonzero   (nonzero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    reset     = 1'b0;
    wen       = 1'b1;
    writedata = 32'hFFFF_FFFF;
    #1;
    chk("rst_rd", readdata, 32'h0);
    chk("rst_wr", {31'b0, wrote}, 32'h0);
    chk("rst_nz", {31'b0, nonzero}, 32'h0);
    step();
    chk("rst_edge_rd", readdata, 32'h0);
    chk("rst_edge_wr", {31'b0, wrote}, 32'h0);

    reset     = 1'b1;
    writedata = 32'h1234_5678;
    wen       = 1'b1;
    step();
    chk("wr_rd", readdata, 32'h1234_5678);
    chk("wr_wr", {31'b0, wrote}, 32'h1);
    chk("wr_nz", {31'b0, nonzero}, 32'h1);
    wen = 1'b0;
    step();
    chk("idle_wr", {31'b0, wrote}, 32'h0);
    chk("idle_rd", readdata, 32'h1234_5678);

    wen       = 1'b1;
    writedata = 32'hABCD_1234;
    step();
    wen       = 1'b0;
    writedata = 32'hFFFF_FFFF;
    repeat (5) step();
    chk("hold_rd", readdata, 32'hABCD_1234);
    chk("hold_wr", {31'b0, wrote}, 32'h0);

    wen       = 1'b1;
    writedata = 32'h1;
    step();
    chk("b2b1_rd", readdata, 32'h1);
    chk("b2b1_wr", {31'b0, wrote}, 32'h1);
    writedata = 32'h2;
    step();
    chk("b2b2_rd", readdata, 32'h2);
    chk("b2b2_wr", {31'b0, wrote}, 32'h1);
    writedata = 32'h0;
    step();
    chk("b2b3_rd", readdata, 32'h0);
    chk("b2b3_wr", {31'b0, wrote}, 32'h1);
    chk("b2b3_nz", {31'b0, nonzero}, 32'h0);
    step();
    chk("same_wr", {31'b0, wrote}, 32'h1);
    chk("same_rd", readdata, 32'h0);

    writedata = 32'h5;
    step();
    wen       = 1'b0;
    step();
    writedata = 32'h9;
    wen       = 1'b1;
    #1;
`ifdef REG32_READ_BYPASS_EN
    chk("byp_pre", readdata, 32'h9);
`else
    chk("byp_pre", readdata, 32'h5);
`endif
    chk("byp_nz", {31'b0, nonzero}, 32'h1);
    step();
    chk("byp_post", readdata, 32'h9);

    writedata = 32'h1234_5678;
    step();
    wen = 1'b0;
    step();
    chk("pre_arst", readdata, 32'h1234_5678);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_rd", readdata, 32'h0);
    chk("arst_wr", {31'b0, wrote}, 32'h0);
    chk("arst_nz", {31'b0, nonzero}, 32'h0);
    #1;
    reset = 1'b1;
    step();
    chk("rel_rd", readdata, 32'h0);
    chk("rel_wr", {31'b0, wrote}, 32'h0);

    wen       = 1'b1;
    writedata = 32'h8000_0000;
    step();
    wen = 1'b0;
    step();
    chk("msb_rd", readdata, 32'h8000_0000);
    chk("msb_nz", {31'b0, nonzero}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg32.md
Name: reg32

Overview:
- General-purpose clocked storage register, 32 bits by default.
- Captures `writedata` on a rising clock edge when `wen` is high and drives the stored value on `readdata`.
- Used as a leaf building block: register-file entries, the latch for the syscall argument/display value, pipeline holding registers.
- Also provides status outputs: a write-strobe echo and a nonzero flag.

Parameters:
- WIDTH, 32, data width in bits; legal range 1..64.
- RESET_VALUE, {WIDTH{1'b0}}, value loaded into the register while reset is asserted.

Ports:
- clk  input  1  clock; all state updates occur on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted); assertion takes effect immediately, release is sampled by clk.
- writedata  input  WIDTH  data to capture.
- wen  input  1  write enable, active-high, sampled on the rising clk edge.
- readdata  output  WIDTH  current stored value.
- wrote  output  1  high for exactly one cycle after a clock edge that performed a write.
- nonzero  output  1  combinational OR-reduction of the stored value.

Behaviour:
- Storage: one WIDTH-bit register q. readdata = q, driven directly from the flop with no combinational path from writedata (except when READ_BYPASS_EN is defined).
- Reset: while reset==0, q is forced to RESET_VALUE and wrote to 0, asynchronously (no clock needed). With default parameters, readdata=0 and nonzero=0 in reset.
- Write: on rising clk with reset==1 and wen==1, q <= writedata. The new value is visible on readdata one edge after capture (latency 1 cycle).
- Hold: on rising clk with wen==0, q keeps its value indefinitely.
- wrote <= (wen && reset) on each rising edge; 0 while in reset.
- Repeated writes: back-to-back writes on consecutive cycles each take effect. wrote stays high continuously while wen is held high.
- Writing the current value is a normal write: wrote pulses even though q is unchanged.
- Reset vs write:
  - If reset asserts mid-cycle after a write, reset wins and q returns to RESET_VALUE.
  - If reset releases coincident with a clock edge where wen==1, that edge must not be relied on. Implementation captures only when reset was already deasserted at the edge.
- X/Z handling: if wen is X at an edge, q becomes X in simulation. No masking is performed.
- No width conversion: writedata and readdata are both exactly WIDTH bits.

Optional Feature:
- Macro: REG32_READ_BYPASS_EN.
- When defined: readdata = (wen && reset) ? writedata : q, combinationally. The value being written appears in the same cycle, for write-before-read register files. q, wrote and nonzero timing are unchanged; nonzero still reflects q.
- When not defined: readdata = q only, with pure 1-cycle write latency.

Test Plan:
- Reset: drive reset=0 with writedata=32'hFFFFFFFF and wen=1 -> readdata=32'h00000000, wrote=0, nonzero=0 immediately, before any clock edge.
- Basic write: reset=1, writedata=32'h12345678, wen=1, one rising edge -> readdata=32'h12345678, wrote=1, nonzero=1. Then wen=0, one edge -> wrote=0, readdata unchanged.
- Hold: after holding 32'hABCD1234, set wen=0, writedata=32'hFFFFFFFF and run 5 edges -> readdata stays 32'hABCD1234.
- Back-to-back: wen=1 with writedata 32'h1, then 32'h2, then 32'h0 on three consecutive edges -> readdata 1, 2, 0 after each respective edge; wrote high all three cycles; nonzero=0 after the third edge.
- Async reset mid-cycle: with q=32'h12345678, pull reset to 0 between clock edges -> readdata=0 without waiting for an edge. Release reset with wen=0 -> readdata stays 0.
- Bypass (REG32_READ_BYPASS_EN defined): q=32'h5, writedata=32'h9, wen=1 before the edge -> readdata=32'h9 combinationally and q=32'h9 after the edge. Without the macro, readdata=32'h5 until the edge.
